// File: rtl/rx_header_parser.sv
// RDMA RX header parser: strips and decodes the 7-beat header,
// checks marker and payload length, forwards payload unchanged.
module rx_header_parser #(
    parameter int          C_AXIS_TDATA_WIDTH = 32,
    parameter int          C_AXIS_TKEEP_WIDTH = 4,
    parameter int          HEADER_BEATS       = 7,
    parameter logic [23:0] MARKER             = 24'hABABAB
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [C_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic [C_AXIS_TKEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    input  logic                          s_axis_tlast,
    output logic                          s_axis_tready,
    output logic [C_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic [C_AXIS_TKEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                          m_axis_tvalid,
    output logic                          m_axis_tlast,
    input  logic                          m_axis_tready,
    output logic [7:0]                    hdr_opcode,
    output logic [23:0]                   hdr_psn,
    output logic [23:0]                   hdr_dest_qp,
    output logic [31:0]                   hdr_remote_addr,
    output logic [15:0]                   hdr_frag_offset,
    output logic [31:0]                   hdr_length,
    output logic [15:0]                   hdr_partition_key,
    output logic [7:0]                    hdr_service_level,
    output logic                          hdr_valid,
    output logic                          rx_busy,
    output logic                          rx_done,
    output logic                          hdr_err,
    output logic                          len_err
);

    typedef enum logic [1:0] {HDR, PAYLOAD, DROP} state_t;

    localparam logic [2:0] LAST_HDR = 3'(HEADER_BEATS - 1);

    state_t      state, state_nxt;
    logic [2:0]  beat_cnt, beat_cnt_nxt;
    logic [31:0] pay_cnt, pay_cnt_nxt;
    logic        hdr_valid_nxt, rx_done_nxt, hdr_err_nxt, len_err_nxt;
    logic        s_hs;
    logic        marker_ok;
    logic [32:0] pay_inc;

    assign s_hs      = s_axis_tvalid && s_axis_tready;
    assign marker_ok = (s_axis_tdata[31:8] == MARKER);
    assign pay_inc   = {1'b0, pay_cnt} + 33'd1;
    assign rx_busy   = (state != HDR) || (beat_cnt != 3'd0);

    assign m_axis_tdata = s_axis_tdata;
    assign m_axis_tkeep = s_axis_tkeep;
    assign m_axis_tlast = s_axis_tlast;

    always_comb begin
        state_nxt     = state;
        beat_cnt_nxt  = beat_cnt;
        pay_cnt_nxt   = pay_cnt;
        hdr_valid_nxt = 1'b0;
        rx_done_nxt   = 1'b0;
        hdr_err_nxt   = 1'b0;
        len_err_nxt   = 1'b0;
        s_axis_tready = 1'b1;
        m_axis_tvalid = 1'b0;
        unique case (state)
            HDR: begin
                if (s_hs) begin
                    if (beat_cnt != LAST_HDR) begin
                        beat_cnt_nxt = beat_cnt + 3'd1;
                        if (s_axis_tlast) begin
                            hdr_err_nxt  = 1'b1;
                            beat_cnt_nxt = 3'd0;
                        end
                    end else begin
                        beat_cnt_nxt = 3'd0;
                        if (!marker_ok) begin
                            hdr_err_nxt = 1'b1;
                            if (!s_axis_tlast) state_nxt = DROP;
                        end else begin
                            hdr_valid_nxt = 1'b1;
                            pay_cnt_nxt   = '0;
                            if (s_axis_tlast) begin
                                rx_done_nxt = 1'b1;
                                len_err_nxt = (hdr_length != 32'd0);
                            end else begin
                                state_nxt = PAYLOAD;
                            end
                        end
                    end
                end
            end
            PAYLOAD: begin
                s_axis_tready = m_axis_tready;
                m_axis_tvalid = s_axis_tvalid;
                if (s_hs) begin
                    pay_cnt_nxt = (&pay_cnt) ? pay_cnt : pay_inc[31:0];
                    if (s_axis_tlast) begin
                        rx_done_nxt  = 1'b1;
                        len_err_nxt  = (pay_inc != {1'b0, hdr_length});
                        beat_cnt_nxt = 3'd0;
                        state_nxt    = HDR;
                    end
                end
            end
            DROP: begin
                if (s_hs && s_axis_tlast) state_nxt = HDR;
            end
            default: state_nxt = HDR;
        endcase
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state     <= HDR;
            beat_cnt  <= '0;
            pay_cnt   <= '0;
            hdr_valid <= 1'b0;
            rx_done   <= 1'b0;
            hdr_err   <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            beat_cnt  <= beat_cnt_nxt;
            pay_cnt   <= pay_cnt_nxt;
            hdr_valid <= hdr_valid_nxt;
            rx_done   <= rx_done_nxt;
            hdr_err   <= hdr_err_nxt;
            len_err   <= len_err_nxt;
        end
    end

    // Field registers load on their own beat, even if the header later fails.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hdr_opcode        <= '0;
            hdr_psn           <= '0;
            hdr_dest_qp       <= '0;
            hdr_remote_addr   <= '0;
            hdr_frag_offset   <= '0;
            hdr_length        <= '0;
            hdr_partition_key <= '0;
            hdr_service_level <= '0;
        end else if (state == HDR && s_hs) begin
            unique case (beat_cnt)
                3'd0: begin
                    hdr_opcode <= s_axis_tdata[7:0];
                    hdr_psn    <= s_axis_tdata[31:8];
                end
                3'd1: hdr_dest_qp       <= s_axis_tdata[23:0];
                3'd2: hdr_remote_addr   <= s_axis_tdata;
                3'd3: hdr_frag_offset   <= s_axis_tdata[15:0];
                3'd4: hdr_length        <= s_axis_tdata;
                3'd5: hdr_partition_key <= s_axis_tdata[15:0];
                3'd6: hdr_service_level <= s_axis_tdata[7:0];
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_header_parser.sv
// Bench for rx_header_parser: packet-level model plus directed
// vectors with hand-computed field values.
module tb_rx_header_parser;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] s_tdata = '0;
    logic [3:0]  s_tkeep = 4'hF;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tkeep;
    logic        m_tvalid;
    logic        m_tlast;
    logic        m_tready = 1'b1;
    logic [7:0]  hdr_opcode;
    logic [23:0] hdr_psn;
    logic [23:0] hdr_dest_qp;
    logic [31:0] hdr_remote_addr;
    logic [15:0] hdr_frag_offset;
    logic [31:0] hdr_length;
    logic [15:0] hdr_partition_key;
    logic [7:0]  hdr_service_level;
    logic        hdr_valid, rx_busy, rx_done, hdr_err, len_err;

    rx_header_parser dut (
        .aclk              (aclk),
        .areset            (areset),
        .s_axis_tdata      (s_tdata),
        .s_axis_tkeep      (s_tkeep),
        .s_axis_tvalid     (s_tvalid),
        .s_axis_tlast      (s_tlast),
        .s_axis_tready     (s_tready),
        .m_axis_tdata      (m_tdata),
        .m_axis_tkeep      (m_tkeep),
        .m_axis_tvalid     (m_tvalid),
        .m_axis_tlast      (m_tlast),
        .m_axis_tready     (m_tready),
        .hdr_opcode        (hdr_opcode),
        .hdr_psn           (hdr_psn),
        .hdr_dest_qp       (hdr_dest_qp),
        .hdr_remote_addr   (hdr_remote_addr),
        .hdr_frag_offset   (hdr_frag_offset),
        .hdr_length        (hdr_length),
        .hdr_partition_key (hdr_partition_key),
        .hdr_service_level (hdr_service_level),
        .hdr_valid         (hdr_valid),
        .rx_busy           (rx_busy),
        .rx_done           (rx_done),
        .hdr_err           (hdr_err),
        .len_err           (len_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [7:0]  op;
        logic [23:0] psn;
        logic [23:0] qp;
        logic [31:0] addr;
        logic [15:0] frag;
        logic [31:0] len;
        logic [15:0] pkey;
        logic [7:0]  sl;
    } hdr_t;

    int vectors = 0;
    int miscompares = 0;
    int exp_hv = 0, exp_he = 0, exp_le = 0, exp_rd = 0;
    int dut_hv = 0, dut_he = 0, dut_le = 0, dut_rd = 0;
    bit bp_en = 1'b0;

    logic [31:0] pkt[$];
    hdr_t        exp_hdr[$];
    logic [32:0] exp_pay[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Expected outcome of a whole packet from its beats alone.
    task automatic model_pkt();
        int n;
        logic [31:0] w;
        hdr_t h;
        n = pkt.size();
        if (n < 7) begin
            exp_he++;
            return;
        end
        w = pkt[6];
        if (w[31:8] != 24'hABABAB) begin
            exp_he++;
            return;
        end
        w = pkt[0]; h.op = w[7:0]; h.psn = w[31:8];
        w = pkt[1]; h.qp = w[23:0];
        h.addr = pkt[2];
        w = pkt[3]; h.frag = w[15:0];
        h.len = pkt[4];
        w = pkt[5]; h.pkey = w[15:0];
        w = pkt[6]; h.sl = w[7:0];
        exp_hdr.push_back(h);
        exp_hv++;
        exp_rd++;
        if (longint'(n - 7) != longint'(pkt[4])) exp_le++;
        for (int i = 7; i < n; i++)
            exp_pay.push_back({(i == n - 1), pkt[i]});
    endtask

    task automatic put(input logic [31:0] d, input logic l);
        bit done;
        s_tdata  = d;
        s_tlast  = l;
        s_tvalid = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge aclk);
            if (s_tready) done = 1'b1;
        end
        if (!done) begin
            miscompares++;
            $display("FAIL put_timeout: s_axis_tready stuck at 0 for beat 0x%08h", d);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic send_pkt();
        model_pkt();
        foreach (pkt[i]) put(pkt[i], (i == pkt.size() - 1));
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic mk_pkt(input logic [31:0] len, input logic [31:0] w6,
                          input int npay, input logic [31:0] base);
        pkt.delete();
        pkt.push_back(32'h00000A06);
        pkt.push_back(32'h00000011);
        pkt.push_back(32'h10000000);
        pkt.push_back(32'h00000000);
        pkt.push_back(len);
        pkt.push_back(32'h0000FFFF);
        pkt.push_back(w6);
        for (int i = 0; i < npay; i++) pkt.push_back(base + 32'(i));
    endtask

    task automatic settle_and_check(input string tag);
        s_tvalid = 1'b0;
        repeat (3) @(posedge aclk);
        #2;
        check({tag, "_hdr_valid_cnt"}, 32'(dut_hv), 32'(exp_hv));
        check({tag, "_hdr_err_cnt"},   32'(dut_he), 32'(exp_he));
        check({tag, "_len_err_cnt"},   32'(dut_le), 32'(exp_le));
        check({tag, "_rx_done_cnt"},   32'(dut_rd), 32'(exp_rd));
        check({tag, "_payload_left"},  32'(exp_pay.size()), 32'd0);
        check({tag, "_rx_busy_idle"},  32'(rx_busy), 32'd0);
    endtask

    always @(posedge aclk) begin
        #1;
        m_tready <= bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic p_hv = 0, p_he = 0, p_le = 0, p_rd = 0;

    always @(negedge aclk) begin
        if (!areset) begin
            if (m_tvalid) begin
                check("pass_ready", 32'(s_tready), 32'(m_tready));
                check("pass_data", m_tdata, s_tdata);
            end
            if (m_tvalid && m_tready) begin
                if (exp_pay.size() == 0) begin
                    check("extra_payload_beat", m_tdata, 32'hDEADBEEF);
                end else begin
                    logic [32:0] e;
                    e = exp_pay.pop_front();
                    check("payload_data", m_tdata, e[31:0]);
                    check("payload_last", 32'(m_tlast), 32'(e[32]));
                end
            end
            if (hdr_valid) begin
                dut_hv++;
                if (exp_hdr.size() == 0) begin
                    check("unexpected_hdr_valid", 32'd1, 32'd0);
                end else begin
                    hdr_t h;
                    h = exp_hdr.pop_front();
                    check("f_opcode", 32'(hdr_opcode), 32'(h.op));
                    check("f_psn", 32'(hdr_psn), 32'(h.psn));
                    check("f_dest_qp", 32'(hdr_dest_qp), 32'(h.qp));
                    check("f_addr", hdr_remote_addr, h.addr);
                    check("f_frag", 32'(hdr_frag_offset), 32'(h.frag));
                    check("f_length", hdr_length, h.len);
                    check("f_pkey", 32'(hdr_partition_key), 32'(h.pkey));
                    check("f_sl", 32'(hdr_service_level), 32'(h.sl));
                end
            end
            if (hdr_err) dut_he++;
            if (len_err) dut_le++;
            if (rx_done) dut_rd++;
            if (hdr_err) check("err_exclusive", 32'(len_err), 32'd0);
            if (hdr_valid) check("hv_width", 32'(p_hv), 32'd0);
            if (hdr_err)   check("he_width", 32'(p_he), 32'd0);
            if (len_err)   check("le_width", 32'(p_le), 32'd0);
            if (rx_done)   check("rd_width", 32'(p_rd), 32'd0);
        end
        p_hv = hdr_valid; p_he = hdr_err; p_le = len_err; p_rd = rx_done;
    end

    initial begin
        #1;
        check("rst_opcode", 32'(hdr_opcode), 32'd0);
        check("rst_length", hdr_length, 32'd0);
        check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("rst_rx_busy", 32'(rx_busy), 32'd0);
        check("rst_pulses", {28'd0, hdr_valid, rx_done, hdr_err, len_err}, 32'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;

        // Nominal packet
        mk_pkt(32'd3, 32'hABABAB05, 3, 32'hA1);
        send_pkt();
        settle_and_check("nominal");
        check("lit_psn", 32'(hdr_psn), 32'h00000A);
        check("lit_opcode", 32'(hdr_opcode), 32'h06);
        check("lit_dest_qp", 32'(hdr_dest_qp), 32'h11);
        check("lit_length", hdr_length, 32'd3);
        check("lit_sl", 32'(hdr_service_level), 32'h05);
        check("lit_pkey", 32'(hdr_partition_key), 32'hFFFF);
        check("lit_addr", hdr_remote_addr, 32'h10000000);

        // Backpressure, then back-to-back packets
        bp_en = 1'b1;
        mk_pkt(32'd3, 32'hABABAB05, 3, 32'hA1);
        send_pkt();
        mk_pkt(32'd6, 32'hABABAB07, 6, 32'hB0);
        send_pkt();
        bp_en = 1'b0;
        settle_and_check("backpressure");

        // Bad marker then good packet
        mk_pkt(32'd2, 32'h12345605, 2, 32'hC1);
        send_pkt();
        settle_and_check("bad_marker");
        mk_pkt(32'd3, 32'hABABAB05, 3, 32'hA1);
        send_pkt();
        settle_and_check("after_bad");

        // Short and long payloads against hdr_length=4
        mk_pkt(32'd4, 32'hABABAB05, 2, 32'hD1);
        send_pkt();
        settle_and_check("short_pay");
        mk_pkt(32'd4, 32'hABABAB05, 5, 32'hE1);
        send_pkt();
        settle_and_check("long_pay");

        // Header-only packets
        mk_pkt(32'd0, 32'hABABAB09, 0, 32'h0);
        send_pkt();
        mk_pkt(32'd1, 32'hABABAB09, 0, 32'h0);
        send_pkt();
        settle_and_check("hdr_only");

        // Truncated header: tlast on beat 3
        mk_pkt(32'd3, 32'hABABAB05, 0, 32'h0);
        while (pkt.size() > 4) void'(pkt.pop_back());
        send_pkt();
        settle_and_check("trunc");
        mk_pkt(32'd3, 32'hABABAB05, 3, 32'hA1);
        send_pkt();
        settle_and_check("after_trunc");

        // Reset after header and one payload beat
        mk_pkt(32'd3, 32'hABABAB05, 3, 32'hA1);
        begin
            hdr_t h;
            h.op = 8'h06; h.psn = 24'h00000A; h.qp = 24'h11;
            h.addr = 32'h10000000; h.frag = 16'h0; h.len = 32'd3;
            h.pkey = 16'hFFFF; h.sl = 8'h05;
            exp_hdr.push_back(h);
        end
        exp_hv++;
        exp_pay.push_back({1'b0, 32'hA1});
        for (int i = 0; i < 8; i++) put(pkt[i], 1'b0);
        s_tvalid = 1'b0;
        areset = 1'b1;
        #1;
        check("arst_opcode", 32'(hdr_opcode), 32'd0);
        check("arst_psn", 32'(hdr_psn), 32'd0);
        check("arst_length", hdr_length, 32'd0);
        check("arst_sl", 32'(hdr_service_level), 32'd0);
        check("arst_m_tvalid", 32'(m_tvalid), 32'd0);
        check("arst_rx_busy", 32'(rx_busy), 32'd0);
        check("arst_pulses", {28'd0, hdr_valid, rx_done, hdr_err, len_err}, 32'd0);
        repeat (2) @(negedge aclk);
        areset = 1'b0;
        @(posedge aclk);
        #1;
        mk_pkt(32'd3, 32'hABABAB05, 3, 32'hA1);
        send_pkt();
        settle_and_check("after_reset");
        check("final_length", hdr_length, 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
